priority_encoder_iter: RTL and testbench

Sequential successor to the combinational priority encoder. It captures an N-bit request vector and emits the index of every set bit, one per accepted output beat, in priority order. Priority is highest-index-first or lowest-index-first, chosen by parameter. Input and output both use valid/ready handshakes, and a synchronous flush aborts a scan. Consumers are multi-bit scanners in the FPU/core datapath, such as normalisation bit walks, pending-exception/interrupt claiming and multi-register sequencing.

---
 rtl/priority_encoder_iter.sv | 116 +++++++++++
 tb/tb_priority_encoder_iter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_iter.sv
// Iterative priority encoder: captures a request vector and emits
// the index of every set bit, one per accepted beat.
module priority_encoder_iter #(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int LogN      = (N == 1) ? 0 : $clog2(N) - 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_vector,
   output logic          in_empty,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [LogN:0] out_index,
   output logic          out_last,
   output logic [LogN:0] out_count,
   output logic          busy
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  rem_q, rem_d, pick;
   logic [LogN:0] idx, cnt_q, cnt_d;
   logic          empty_q, empty_d;
   logic          single;

   // Last matching bit in scan order wins, so the loop direction
   // selects which end of the vector has priority.
   always_comb begin
      idx  = '0;
      pick = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < N; i++) begin
            if (rem_q[i]) begin
               idx     = (LogN+1)'(i);
               pick    = '0;
               pick[i] = 1'b1;
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
               idx     = (LogN+1)'(i);
               pick    = '0;
               pick[i] = 1'b1;
            end
         end
      end
   end

   assign single = (rem_q != '0) &&
                   ((rem_q & (rem_q - N'(1))) == '0);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      empty_d = 1'b0;
      if (flush) begin
         state_d = IDLE;
         rem_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (in_vector != '0) begin
                     rem_d   = in_vector;
                     cnt_d   = '0;
                     state_d = SCAN;
                  end else begin
                     empty_d = 1'b1;
                  end
               end
            end
            SCAN: begin
               if (out_ready) begin
                  rem_d = rem_q & ~pick;
                  cnt_d = cnt_q + (LogN+1)'(1);
                  if (single) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
      end
   end

   assign busy      = (state_q == SCAN);
   assign out_valid = busy;
   assign in_ready  = ~busy;
   assign out_index = busy ? idx : '0;
   assign out_last  = busy & single;
   assign out_count = cnt_q;
   assign in_empty  = empty_q;

endmodule

// File: tb/tb_priority_encoder_iter.sv
// Directed bench for priority_encoder_iter: N=8 MSB-first,
// N=5 LSB-first and N=1 instances on a shared clock.
module tb_priority_encoder_iter;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic flush = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   logic       a_iv = 0, a_ir, a_emp, a_ov, a_or = 0, a_last, a_busy;
   logic [7:0] a_vec = '0;
   logic [2:0] a_idx, a_cnt;

   logic       b_iv = 0, b_ir, b_emp, b_ov, b_or = 0, b_last, b_busy;
   logic [4:0] b_vec = '0;
   logic [2:0] b_idx, b_cnt;

   logic       c_iv = 0, c_ir, c_emp, c_ov, c_or = 0, c_last, c_busy;
   logic [0:0] c_vec = '0;
   logic [0:0] c_idx, c_cnt;

   priority_encoder_iter #(.N(8), .MSB_FIRST(1'b1)) u8 (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(a_iv), .in_ready(a_ir), .in_vector(a_vec),
      .in_empty(a_emp), .out_valid(a_ov), .out_ready(a_or),
      .out_index(a_idx), .out_last(a_last), .out_count(a_cnt),
      .busy(a_busy));

   priority_encoder_iter #(.N(5), .MSB_FIRST(1'b0)) u5 (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(b_iv), .in_ready(b_ir), .in_vector(b_vec),
      .in_empty(b_emp), .out_valid(b_ov), .out_ready(b_or),
      .out_index(b_idx), .out_last(b_last), .out_count(b_cnt),
      .busy(b_busy));

   priority_encoder_iter #(.N(1), .MSB_FIRST(1'b1)) u1 (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(c_iv), .in_ready(c_ir), .in_vector(c_vec),
      .in_empty(c_emp), .out_valid(c_ov), .out_ready(c_or),
      .out_index(c_idx), .out_last(c_last), .out_count(c_cnt),
      .busy(c_busy));

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      #12;
      tests++;
      if ({a_ov, a_idx, a_last, a_busy, a_ir, a_cnt, a_emp}
          !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
         fails++;
         $display("FAIL reset_u8 got ov=%b idx=%0d last=%b busy=%b ir=%b cnt=%0d emp=%b want 0,0,0,0,1,0,0",
                  a_ov, a_idx, a_last, a_busy, a_ir, a_cnt, a_emp);
      end
      tests++;
      if ({b_ov, b_ir, c_ov, c_ir} !== 4'b0101) begin
         fails++;
         $display("FAIL reset_others got %b want 0101",
                  {b_ov, b_ir, c_ov, c_ir});
      end
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_msb_drain;
      logic [2:0] exp_idx [4] = '{3'd7, 3'd5, 3'd2, 3'd0};
      a_vec = 8'hA5;
      a_iv  = 1'b1;
      a_or  = 1'b1;
      tick();
      a_iv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if ({a_ov, a_idx, a_cnt, a_last, a_ir} !==
             {1'b1, exp_idx[i], 3'(i), (i == 3), 1'b0}) begin
            fails++;
            $display("FAIL msb_beat%0d got ov=%b idx=%0d cnt=%0d last=%b ir=%b want 1,%0d,%0d,%0d,0",
                     i, a_ov, a_idx, a_cnt, a_last, a_ir,
                     exp_idx[i], i, (i == 3));
         end
         tick();
      end
      tests++;
      if ({a_ov, a_ir, a_idx, a_last} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
         fails++;
         $display("FAIL msb_after got ov=%b ir=%b idx=%0d last=%b want 0,1,0,0",
                  a_ov, a_ir, a_idx, a_last);
      end
      a_or = 1'b0;
   endtask

   task automatic test_lsb_stall;
      logic       rdy  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [2:0] eidx [5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd4};
      logic [2:0] ecnt [5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2};
      logic       elst [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      b_vec = 5'b10011;
      b_iv  = 1'b1;
      tick();
      b_iv = 1'b0;
      for (int i = 0; i < 5; i++) begin
         b_or = rdy[i];
         tests++;
         if ({b_ov, b_idx, b_cnt, b_last} !==
             {1'b1, eidx[i], ecnt[i], elst[i]}) begin
            fails++;
            $display("FAIL lsb_cycle%0d got ov=%b idx=%0d cnt=%0d last=%b want 1,%0d,%0d,%b",
                     i, b_ov, b_idx, b_cnt, b_last,
                     eidx[i], ecnt[i], elst[i]);
         end
         tick();
      end
      b_or = 1'b0;
      tests++;
      if ({b_ov, b_ir, b_cnt} !== {1'b0, 1'b1, 3'd0}) begin
         fails++;
         $display("FAIL lsb_after got ov=%b ir=%b cnt=%0d want 0,1,0",
                  b_ov, b_ir, b_cnt);
      end
   endtask

   task automatic test_empty;
      a_vec = 8'h00;
      a_iv  = 1'b1;
      tick();
      tests++;
      if ({a_emp, a_ov, a_ir} !== 3'b101) begin
         fails++;
         $display("FAIL empty_pulse got emp=%b ov=%b ir=%b want 1,0,1",
                  a_emp, a_ov, a_ir);
      end
      a_vec = 8'h01;
      a_or  = 1'b1;
      tick();
      a_iv = 1'b0;
      tests++;
      if ({a_emp, a_ov, a_idx, a_last, a_cnt} !==
          {1'b0, 1'b1, 3'd0, 1'b1, 3'd0}) begin
         fails++;
         $display("FAIL empty_next got emp=%b ov=%b idx=%0d last=%b cnt=%0d want 0,1,0,1,0",
                  a_emp, a_ov, a_idx, a_last, a_cnt);
      end
      tick();
      tests++;
      if ({a_ov, a_ir, a_emp} !== 3'b010) begin
         fails++;
         $display("FAIL empty_done got ov=%b ir=%b emp=%b want 0,1,0",
                  a_ov, a_ir, a_emp);
      end
      a_or = 1'b0;
   endtask

   task automatic test_flush;
      logic [2:0] eidx [3] = '{3'd7, 3'd6, 3'd5};
      a_vec = 8'hFF;
      a_iv  = 1'b1;
      a_or  = 1'b1;
      tick();
      a_iv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if ({a_ov, a_idx, a_cnt} !== {1'b1, eidx[i], 3'(i)}) begin
            fails++;
            $display("FAIL flush_beat%0d got ov=%b idx=%0d cnt=%0d want 1,%0d,%0d",
                     i, a_ov, a_idx, a_cnt, eidx[i], i);
         end
         if (i == 2) flush = 1'b1;
         tick();
      end
      flush = 1'b0;
      tests++;
      if ({a_ov, a_ir, a_busy, a_cnt, a_idx} !==
          {1'b0, 1'b1, 1'b0, 3'd0, 3'd0}) begin
         fails++;
         $display("FAIL flush_after got ov=%b ir=%b busy=%b cnt=%0d idx=%0d want 0,1,0,0,0",
                  a_ov, a_ir, a_busy, a_cnt, a_idx);
      end
      a_vec = 8'h10;
      a_iv  = 1'b1;
      tick();
      a_iv = 1'b0;
      tests++;
      if ({a_ov, a_idx, a_last, a_cnt} !==
          {1'b1, 3'd4, 1'b1, 3'd0}) begin
         fails++;
         $display("FAIL flush_new got ov=%b idx=%0d last=%b cnt=%0d want 1,4,1,0",
                  a_ov, a_idx, a_last, a_cnt);
      end
      tick();
      tests++;
      if (a_ov !== 1'b0) begin
         fails++;
         $display("FAIL flush_new_done got ov=%b want 0", a_ov);
      end
      a_or = 1'b0;
   endtask

   task automatic test_async_reset;
      a_vec = 8'hF0;
      a_iv  = 1'b1;
      a_or  = 1'b0;
      tick();
      a_iv = 1'b0;
      tests++;
      if ({a_ov, a_idx, a_busy} !== {1'b1, 3'd7, 1'b1}) begin
         fails++;
         $display("FAIL areset_pre got ov=%b idx=%0d busy=%b want 1,7,1",
                  a_ov, a_idx, a_busy);
      end
      #3;
      reset_n = 1'b0;
      #1;
      tests++;
      if ({a_ov, a_busy, a_idx, a_last, a_ir} !==
          {1'b0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL areset_mid got ov=%b busy=%b idx=%0d last=%b ir=%b want 0,0,0,0,1",
                  a_ov, a_busy, a_idx, a_last, a_ir);
      end
      tick();
      reset_n = 1'b1;
      tests++;
      if ({a_ir, a_ov} !== 2'b10) begin
         fails++;
         $display("FAIL areset_rel got ir=%b ov=%b want 1,0", a_ir, a_ov);
      end
      a_vec = 8'h03;
      a_iv  = 1'b1;
      a_or  = 1'b1;
      tick();
      a_iv = 1'b0;
      tests++;
      if ({a_ov, a_idx, a_last} !== {1'b1, 3'd1, 1'b0}) begin
         fails++;
         $display("FAIL areset_b0 got ov=%b idx=%0d last=%b want 1,1,0",
                  a_ov, a_idx, a_last);
      end
      tick();
      tests++;
      if ({a_ov, a_idx, a_last, a_cnt} !== {1'b1, 3'd0, 1'b1, 3'd1}) begin
         fails++;
         $display("FAIL areset_b1 got ov=%b idx=%0d last=%b cnt=%0d want 1,0,1,1",
                  a_ov, a_idx, a_last, a_cnt);
      end
      tick();
      a_or = 1'b0;
   endtask

   task automatic test_n1;
      int beats = 0;
      c_vec = 1'b1;
      c_iv  = 1'b1;
      tick();
      c_iv = 1'b0;
      for (int i = 0; i < 12; i++) begin
         c_or = (i >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
         if (c_ov) begin
            tests++;
            if ({c_idx, c_last, c_cnt} !== {1'b0, 1'b1, 1'b0}) begin
               fails++;
               $display("FAIL n1_beat got idx=%0d last=%b cnt=%0d want 0,1,0",
                        c_idx, c_last, c_cnt);
            end
            if (c_or) beats++;
         end
         tick();
      end
      c_or = 1'b0;
      tests++;
      if (beats != 1) begin
         fails++;
         $display("FAIL n1_count got %0d beats want 1", beats);
      end
   endtask

   initial begin
      test_reset();
      test_msb_drain();
      test_lsb_stall();
      test_empty();
      test_flush();
      test_async_reset();
      test_n1();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
